// File: rtl/stable_bit_tx.sv
// stable_bit_tx: serial transmitter for the enable/data line pair.
// A word accepted over valid/ready is shifted out one bit at a time. Each bit
// is first driven with enable low for GAP cycles, then enable is raised for
// HOLD cycles while the bit is held, so data never moves while enable is high.

// Line-protocol checker for the transmitter outputs and internal counters.
module stable_bit_tx_chk #(
    parameter int WIDTH = 8,
    parameter int MAXC  = 2,
    parameter int BCW   = 4,
    parameter int CCW   = 2
) (
    input logic           clk,
    input logic           rst,
    input logic           enable,
    input logic           data,
    input logic           in_ready,
    input logic           busy,
    input logic           done,
    input logic [BCW-1:0] bits_cnt,
    input logic [CCW-1:0] cyc_cnt
);

    // data is stable across every cycle in which enable is high
    a_stable : assert property (@(posedge clk) disable iff (rst)
        enable |-> (data == $past(data)));

    // the block never offers to accept while a frame is in flight
    a_ready_busy : assert property (@(posedge clk) disable iff (rst)
        !(in_ready && busy));

    // done only appears in the idle cycle that ends a frame
    a_done_idle : assert property (@(posedge clk) disable iff (rst)
        done |-> (!enable && !busy && in_ready));

    // the bit counter never exceeds the word length
    a_bits_range : assert property (@(posedge clk) disable iff (rst)
        bits_cnt <= BCW'(WIDTH));

    // the cycle counter never reaches the longer of the two phase lengths
    a_cyc_range : assert property (@(posedge clk) disable iff (rst)
        cyc_cnt < CCW'(MAXC));

endmodule

// Transmitter top level.
module stable_bit_tx #(
    parameter int WIDTH     = 8,
    parameter int HOLD      = 2,
    parameter int GAP       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             enable,
    output logic             data,
    output logic             busy,
    output logic             done
);

    localparam int BCW  = $clog2(WIDTH + 1);
    localparam int MAXC = (GAP > HOLD) ? GAP : HOLD;
    localparam int CCW  = $clog2(MAXC + 1);
    localparam bit MSB  = (MSB_FIRST != 0);

    localparam logic [BCW-1:0] BITS_FULL = BCW'(WIDTH);
    localparam logic [BCW-1:0] BITS_ONE  = BCW'(1);
    localparam logic [CCW-1:0] GAP_LOAD  = CCW'(GAP - 1);
    localparam logic [CCW-1:0] HOLD_LOAD = CCW'(HOLD - 1);
    localparam logic [CCW-1:0] CYC_ONE   = CCW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shift_adv;
    logic [BCW-1:0]   r_bits;
    logic [BCW-1:0]   w_bits_nxt;
    logic [CCW-1:0]   r_cyc;
    logic [CCW-1:0]   w_cyc_nxt;
    logic             r_enable;
    logic             w_enable_nxt;
    logic             r_data;
    logic             w_data_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_ready;
    logic             w_ready_nxt;

    // Bit that goes on the line first for a given shift-register image.
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        if (MSB) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    // Shift register image after the current bit has been consumed.
    always_comb begin
        if (MSB) begin
            w_shift_adv = r_shift << 1;
        end else begin
            w_shift_adv = r_shift >> 1;
        end
    end

    // Next-state and next-output logic; data only moves on edges that leave enable low.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bits_nxt   = r_bits;
        w_cyc_nxt    = r_cyc;
        w_enable_nxt = r_enable;
        w_data_nxt   = r_data;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_enable_nxt = 1'b0;
                if (in_valid && r_ready) begin
                    w_shift_nxt = in_data;
                    w_data_nxt  = first_bit(in_data);
                    w_bits_nxt  = BITS_FULL;
                    w_cyc_nxt   = GAP_LOAD;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_cyc == '0) begin
                    // raise enable; data is left untouched on this edge
                    w_enable_nxt = 1'b1;
                    w_cyc_nxt    = HOLD_LOAD;
                    w_state_nxt  = ST_HOLD;
                end else begin
                    w_cyc_nxt = r_cyc - CYC_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cyc == '0) begin
                    w_enable_nxt = 1'b0;
                    if (r_bits <= BITS_ONE) begin
                        // last bit finished: data keeps the final bit
                        w_bits_nxt  = '0;
                        w_cyc_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_shift_nxt = w_shift_adv;
                        w_data_nxt  = first_bit(w_shift_adv);
                        w_bits_nxt  = r_bits - BITS_ONE;
                        w_cyc_nxt   = GAP_LOAD;
                        w_state_nxt = ST_GAP;
                    end
                end else begin
                    w_cyc_nxt = r_cyc - CYC_ONE;
                end
            end
            default: begin
                w_enable_nxt = 1'b0;
                w_bits_nxt   = '0;
                w_cyc_nxt    = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // Status flags follow the next state so they are registered like the line.
    always_comb begin
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, counters and registered outputs; reset forces everything low at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_bits   <= '0;
            r_cyc    <= '0;
            r_enable <= 1'b0;
            r_data   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_shift  <= w_shift_nxt;
            r_bits   <= w_bits_nxt;
            r_cyc    <= w_cyc_nxt;
            r_enable <= w_enable_nxt;
            r_data   <= w_data_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign in_ready = r_ready;
    assign enable   = r_enable;
    assign data     = r_data;
    assign busy     = r_busy;
    assign done     = r_done;

    stable_bit_tx_chk #(
        .WIDTH (WIDTH),
        .MAXC  (MAXC),
        .BCW   (BCW),
        .CCW   (CCW)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .enable   (r_enable),
        .data     (r_data),
        .in_ready (r_ready),
        .busy     (r_busy),
        .done     (r_done),
        .bits_cnt (r_bits),
        .cyc_cnt  (r_cyc)
    );

endmodule

// File: tb/tb_stable_bit_tx.sv
// Testbench for stable_bit_tx: three instances with different timing
// parameters share one clock and reset. Stimulus pushes hand-computed
// expected bits and done timing into per-instance queues; one monitor
// process compares the line against them on every falling edge.
module tb_stable_bit_tx;

    function automatic int wsel(input int g);
        case (g)
            2:       return 3;
            default: return 8;
        endcase
    endfunction

    function automatic int hsel(input int g);
        case (g)
            1:       return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int gsel(input int g);
        case (g)
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int msel(input int g);
        case (g)
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    logic       clk;
    logic       rst;
    logic       vld [3];
    logic       rdy [3];
    logic [7:0] din [3];
    logic       en  [3];
    logic       dat [3];
    logic       bsy [3];
    logic       dn  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = wsel(g);
        stable_bit_tx #(
            .WIDTH     (W),
            .HOLD      (hsel(g)),
            .GAP       (gsel(g)),
            .MSB_FIRST (msel(g))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (vld[g]),
            .in_ready (rdy[g]),
            .in_data  (din[g][W-1:0]),
            .enable   (en[g]),
            .data     (dat[g]),
            .busy     (bsy[g]),
            .done     (dn[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard queues
    bit exp_bit  [3][$];
    int exp_done [3][$];
    int exp_busy [3][$];

    int n_checks = 0;
    int n_fail   = 0;
    bit end_req  = 1'b0;
    bit end_done = 1'b0;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, g, $time, act, exp);
        end
    endtask

    // monitor state
    int   cyc      [3];
    int   busy_cnt [3];
    int   lo_run   [3];
    int   hi_run   [3];
    logic prev_acc [3];
    logic prev_en  [3];
    logic prev_dat [3];
    int   rel_cnt = 0;

    // Monitor: compares the line of every instance against the scoreboard.
    always @(negedge clk) begin
        if (rst) rel_cnt = 0;
        else     rel_cnt++;
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                check("reset_outputs", g, {27'd0, en[g], dat[g], bsy[g], dn[g], rdy[g]}, 32'd0);
                exp_bit[g].delete();
                exp_done[g].delete();
                exp_busy[g].delete();
                cyc[g] = 0; busy_cnt[g] = 0; lo_run[g] = 0; hi_run[g] = 0;
                prev_acc[g] = 1'b0; prev_en[g] = 1'b0; prev_dat[g] = 1'b0;
            end else begin
                if (prev_acc[g]) begin
                    cyc[g] = 1;
                    busy_cnt[g] = 0;
                end else begin
                    cyc[g]++;
                end
                if (bsy[g]) busy_cnt[g]++;
                if (rel_cnt == 2) check("ready_after_reset", g, rdy[g], 1);
                if (en[g]) begin
                    check("stable_while_enable", g, dat[g], prev_dat[g]);
                    if (!prev_en[g]) begin
                        check("gap_length", g, lo_run[g], gsel(g));
                        check("bit_expected", g, exp_bit[g].size() != 0, 1);
                        if (exp_bit[g].size() != 0) check("bit_value", g, dat[g], exp_bit[g].pop_front());
                        hi_run[g] = 1;
                    end else begin
                        hi_run[g]++;
                    end
                    lo_run[g] = 0;
                end else begin
                    if (prev_en[g]) check("hold_length", g, hi_run[g], hsel(g));
                    lo_run[g] = bsy[g] ? lo_run[g] + 1 : 0;
                    hi_run[g] = 0;
                end
                if (dn[g]) begin
                    check("done_expected", g, exp_done[g].size() != 0, 1);
                    if (exp_done[g].size() != 0) begin
                        check("done_cycle", g, cyc[g], exp_done[g].pop_front());
                        check("busy_cycles", g, busy_cnt[g], exp_busy[g].pop_front());
                    end
                    check("ready_at_done", g, rdy[g], 1);
                end
                prev_acc[g] = vld[g] & rdy[g];
                prev_en[g]  = en[g];
                prev_dat[g] = dat[g];
            end
        end
        if (end_req && !end_done) begin
            for (int g = 0; g < 3; g++) begin
                check("bits_left", g, exp_bit[g].size(), 0);
                check("frames_left", g, exp_done[g].size(), 0);
            end
            end_done = 1'b1;
        end
    end

    // seq lists the bits in send order, seq[n-1] first
    task automatic expect_frame(input int g, input logic [7:0] seq, input int n, input int dcyc, input int bcyc);
        for (int i = n - 1; i >= 0; i--) exp_bit[g].push_back(seq[i]);
        exp_done[g].push_back(dcyc);
        exp_busy[g].push_back(bcyc);
    endtask

    task automatic acc_wait(input int g);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdy[g] && !rst) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        $display("FAIL accept_timeout dut%0d: in_ready never rose", g);
        $fatal(1, "accept timeout");
    endtask

    task automatic send(input int g, input logic [7:0] word);
        din[g] = word;
        vld[g] = 1'b1;
        acc_wait(g);
        vld[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_done[g].size() == 0) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                return;
            end
        end
        $display("FAIL frame_timeout dut%0d: done never arrived", g);
        $fatal(1, "frame timeout");
    endtask

    // Stimulus: directed frames with hand-computed bit sequences and timing.
    initial begin
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            vld[g] = 1'b0;
            din[g] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // single frame 0xA5, MSB first, GAP=1 HOLD=2
        expect_frame(0, 8'b1010_0101, 8, 25, 24);
        send(0, 8'hA5);
        wait_idle(0);

        // LSB first 0x01 with minimum timing
        expect_frame(1, 8'b1000_0000, 8, 17, 16);
        send(1, 8'h01);
        wait_idle(1);

        // back-to-back 0xFF then 0x00 with in_valid held high
        expect_frame(0, 8'b1111_1111, 8, 25, 24);
        expect_frame(0, 8'b0000_0000, 8, 25, 24);
        din[0] = 8'hFF;
        vld[0] = 1'b1;
        acc_wait(0);
        din[0] = 8'h00;
        acc_wait(0);
        vld[0] = 1'b0;
        wait_idle(0);

        // backpressure: 0x3C offered mid-frame waits for the next accept
        expect_frame(0, 8'b1100_0011, 8, 25, 24);
        expect_frame(0, 8'b0011_1100, 8, 25, 24);
        send(0, 8'hC3);
        repeat (5) @(posedge clk);
        #1;
        din[0] = 8'h3C;
        vld[0] = 1'b1;
        acc_wait(0);
        vld[0] = 1'b0;
        wait_idle(0);

        // reset during the 4th bit's hold, then 0x5A
        expect_frame(0, 8'b1111_0000, 8, 25, 24);
        send(0, 8'hF0);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_frame(0, 8'b0101_1010, 8, 25, 24);
        send(0, 8'h5A);
        wait_idle(0);

        // WIDTH=3 GAP=3 HOLD=4, send 0b110
        expect_frame(2, 8'b0000_0110, 3, 22, 21);
        send(2, 8'h06);
        wait_idle(2);

        end_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
